// File: rtl/stream_mux_rr_if.sv
// Stream bundle between N producers, the multiplexer and a single consumer.
interface stream_mux_rr_if #(
  parameter int unsigned DATA_WIDTH = 35,
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned SEL_WIDTH  = 3
);
  logic [NUM_CH*DATA_WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]            in_valid;
  logic [NUM_CH-1:0]            in_ready;
  logic [DATA_WIDTH-1:0]        out_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [SEL_WIDTH-1:0]         out_channel;

  // Environment side: drives producer words and the consumer ready.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_channel
  );

  // Multiplexer side.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_channel
  );
endinterface

// File: rtl/stream_mux_rr.sv
// Registered N:1 stream multiplexer with fixed-select or round-robin arbitration
// and a one-entry output register sustaining one word per cycle.
module stream_mux_rr #(
  parameter int unsigned DATA_WIDTH = 35,
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned SEL_WIDTH  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode,
  input  logic [SEL_WIDTH-1:0] select,
  input  logic                 enable,
  stream_mux_rr_if.slave       bus
);

  localparam logic [SEL_WIDTH-1:0] PTR_RST = SEL_WIDTH'(NUM_CH - 1);

  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_WIDTH-1:0]  out_channel_q, out_channel_d;
  logic                  out_valid_q, out_valid_d;
  logic [SEL_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;

  logic                  slot_free;
  logic                  can_grant;
  logic                  grant_vld;
  logic [SEL_WIDTH-1:0]  grant_idx;
  logic [DATA_WIDTH-1:0] grant_word;
  int                    idx;

  // Grant decision; the round-robin search starts just after the last winner.
  always_comb begin
    slot_free = !out_valid_q || bus.out_ready;
    can_grant = !reset && enable && slot_free;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    if (can_grant) begin
      if (!mode) begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
          if (select == SEL_WIDTH'(i) && bus.in_valid[i]) begin
            grant_vld = 1'b1;
            grant_idx = SEL_WIDTH'(i);
          end
        end
      end else begin
        for (int k = 1; k <= int'(NUM_CH); k++) begin
          idx = (int'(rr_ptr_q) + k) % int'(NUM_CH);
          for (int i = 0; i < int'(NUM_CH); i++) begin
            if (!grant_vld && i == idx && bus.in_valid[i]) begin
              grant_vld = 1'b1;
              grant_idx = SEL_WIDTH'(i);
            end
          end
        end
      end
    end
  end

  // One-hot accept toward the winning producer and its word.
  always_comb begin
    bus.in_ready = '0;
    grant_word   = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (grant_vld && grant_idx == SEL_WIDTH'(i)) begin
        bus.in_ready[i] = 1'b1;
        grant_word      = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Output slot: a new grant replaces a draining word with no bubble.
  always_comb begin
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    out_valid_d   = out_valid_q;
    rr_ptr_d      = rr_ptr_q;
    if (grant_vld) begin
      out_data_d    = grant_word;
      out_channel_d = grant_idx;
      out_valid_d   = 1'b1;
      if (mode) begin
        rr_ptr_d = grant_idx;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q    <= '0;
      out_channel_q <= '0;
      out_valid_q   <= 1'b0;
      rr_ptr_q      <= PTR_RST;
    end else begin
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      out_valid_q   <= out_valid_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  assign bus.out_data    = out_data_q;
  assign bus.out_channel = out_channel_q;
  assign bus.out_valid   = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: an 8-channel instance exercised in both
// modes, plus a 6-channel instance held at an out-of-range select.
module tb_stream_mux_rr;

  localparam int unsigned DW  = 35;
  localparam int unsigned N   = 8;
  localparam int unsigned SW  = 3;
  localparam int unsigned N6  = 6;

  typedef struct {
    int          ch;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          mode;
  logic [SW-1:0] select;
  logic          enable;
  logic          mode6;
  logic [SW-1:0] select6;
  logic          enable6;

  stream_mux_rr_if #(.DATA_WIDTH(DW), .NUM_CH(N),  .SEL_WIDTH(SW)) bus  ();
  stream_mux_rr_if #(.DATA_WIDTH(DW), .NUM_CH(N6), .SEL_WIDTH(SW)) bus6 ();

  stream_mux_rr #(.DATA_WIDTH(DW), .NUM_CH(N), .SEL_WIDTH(SW)) dut (
    .clk    (clk),
    .reset  (reset),
    .mode   (mode),
    .select (select),
    .enable (enable),
    .bus    (bus)
  );

  stream_mux_rr #(.DATA_WIDTH(DW), .NUM_CH(N6), .SEL_WIDTH(SW)) dut6 (
    .clk    (clk),
    .reset  (reset),
    .mode   (mode6),
    .select (select6),
    .enable (enable6),
    .bus    (bus6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  logic m_valid;
  int   m_ptr;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    return DW'({$urandom(), $urandom()});
  endfunction

  function automatic logic [DW-1:0] get_word(input int ch);
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < int'(N); i++)
      if (i == ch) w = bus.in_data[i*DW +: DW];
    return w;
  endfunction

  task automatic fill_data();
    for (int i = 0; i < int'(N); i++) bus.in_data[i*DW +: DW] = rand_word();
  endtask

  // Reference model of one clock: predicts in_ready, checks outputs, updates the scoreboard.
  task automatic step();
    bit        can;
    int        g;
    logic [N-1:0] exp_ready;
    exp_t      e;
    @(negedge clk);
    can = !reset && enable && (!m_valid || bus.out_ready);
    g   = -1;
    if (can) begin
      if (!mode) begin
        if (int'(select) < int'(N) && bus.in_valid[select]) g = int'(select);
      end else begin
        for (int k = 1; k <= int'(N); k++) begin
          int c;
          c = (m_ptr + k) % int'(N);
          if (g < 0 && bus.in_valid[c]) g = c;
        end
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
    check("out_valid", 64'(bus.out_valid), 64'(m_valid));
    if (m_valid && exp_q.size() > 0) begin
      e = exp_q[0];
      check("out_data", 64'(bus.out_data), 64'(e.data));
      check("out_channel", 64'(bus.out_channel), 64'(e.ch));
      if (bus.out_ready) void'(exp_q.pop_front());
    end
    if (reset) begin
      m_valid = 1'b0;
      m_ptr   = int'(N) - 1;
      exp_q.delete();
    end else if (g >= 0) begin
      e.ch   = g;
      e.data = get_word(g);
      exp_q.push_back(e);
      m_valid = 1'b1;
      if (mode) m_ptr = g;
    end else if (bus.out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    mode   = 1'b0;
    select = '0;
    enable = 1'b1;
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
    fill_data();
    mode6   = 1'b0;
    select6 = 3'd7;
    enable6 = 1'b1;
    bus6.in_valid  = '1;
    bus6.out_ready = 1'b1;
    for (int i = 0; i < int'(N6); i++) bus6.in_data[i*DW +: DW] = rand_word();
    m_valid = 1'b0;
    m_ptr   = int'(N) - 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_channel", 64'(bus.out_channel), 64'd0);
    step();
    reset = 1'b0;

    // Fixed select of channel 5.
    mode = 1'b0; select = 3'd5; bus.in_valid = 8'b0010_0000;
    fill_data();
    bus.in_data[5*DW +: DW] = 35'h1_2345_6789;
    step();
    check("fix_data", 64'(bus.out_data), 64'h1_2345_6789);
    check("fix_channel", 64'(bus.out_channel), 64'd5);
    bus.in_valid = '0;
    step();

    // Round-robin fairness from a fresh reset.
    reset = 1'b1; step(); reset = 1'b0;
    mode = 1'b1; bus.in_valid = '1;
    for (int k = 0; k < 10; k++) begin
      fill_data();
      step();
      check("rr_seq", 64'(bus.out_channel), 64'(k % int'(N)));
      check("rr_nogap", 64'(bus.out_valid), 64'd1);
    end
    bus.in_valid = '0;
    step();

    // Back-pressure on a held channel-2 word, then seamless handover to channel 3.
    mode = 1'b0; select = 3'd2; bus.in_valid = 8'b0000_0100; fill_data();
    step();
    select = 3'd3; bus.in_valid = 8'b0000_1000; bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      fill_data();
      step();
      check("bp_channel", 64'(bus.out_channel), 64'd2);
    end
    bus.out_ready = 1'b1;
    step();
    check("bp_handover_ch", 64'(bus.out_channel), 64'd3);
    check("bp_handover_v", 64'(bus.out_valid), 64'd1);
    bus.in_valid = '0;
    step();

    // Sparse round-robin wrapping past the last granted channel 6.
    mode = 1'b1; bus.in_valid = 8'b0100_0000; fill_data();
    step();
    check("sp_ch6", 64'(bus.out_channel), 64'd6);
    bus.in_valid = 8'b0000_0101; fill_data();
    step();
    check("sp_wrap_ch0", 64'(bus.out_channel), 64'd0);
    fill_data();
    step();
    check("sp_ch2", 64'(bus.out_channel), 64'd2);
    bus.in_valid = '0;
    step();

    // Enable low blocks grants while the held word still drains.
    bus.in_valid = '1; fill_data();
    step();
    check("en_grant_ch3", 64'(bus.out_channel), 64'd3);
    enable = 1'b0;
    step();
    check("en_drained", 64'(bus.out_valid), 64'd0);
    step();
    enable = 1'b1;
    bus.in_valid = '0;

    // Reset while holding a channel-4 word under back-pressure.
    mode = 1'b0; select = 3'd4; bus.in_valid = 8'b0001_0000; fill_data();
    step();
    bus.out_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_data", 64'(bus.out_data), 64'd0);
    bus.out_ready = 1'b1;
    mode = 1'b1; bus.in_valid = '1; fill_data();
    step();
    check("mid_rst_first_rr", 64'(bus.out_channel), 64'd0);
    bus.in_valid = '0;
    step();
    step();

    // Six-channel instance with select 7 never grants.
    for (int k = 0; k < 5; k++) begin
      step();
      check("oor_in_ready", 64'(bus6.in_ready), 64'd0);
      check("oor_out_valid", 64'(bus6.out_valid), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised, registered N-channel multiplexer. It is the successor to the fixed 8:1 combinational mux.
- It adds a per-channel valid/ready handshake and a one-entry output register.
- It has two selection modes:
  - fixed: an external select chooses the channel.
  - round-robin: fair arbitration across all channels.
- It sits between multiple producer datapaths (for example, per-source 35-bit words) and a single downstream consumer.

Parameters:
- DATA_WIDTH, 35, width of each channel's data word.
- NUM_CH, 8, number of input channels (2..16).
- SEL_WIDTH, 3, width of select and out_channel; must satisfy 2**SEL_WIDTH >= NUM_CH.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  NUM_CH*DATA_WIDTH  packed channel words; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel accept; one-hot or zero.
- mode  input  1  0 = fixed select, 1 = round-robin.
- select  input  SEL_WIDTH  channel index used in fixed mode.
- enable  input  1  1 = new grants allowed; 0 = no new grants.
- out_data  output  DATA_WIDTH  registered selected word.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  downstream accept.
- out_channel  output  SEL_WIDTH  index of the channel that sourced out_data.

Behaviour:
- Everything is synchronous to clk. Reset is synchronous, active-high.
- Reset values:
  - out_valid = 0, out_data = 0, out_channel = 0.
  - rr_ptr (last-granted index) = NUM_CH-1, so channel 0 has first priority after reset.
- Reset asserted mid-transfer discards the held word. in_ready is 0 while reset is high.
- Slot free condition: slot_free = !out_valid | out_ready.
- A grant is possible only when all of these hold: reset = 0, enable = 1, and slot_free = 1.
- Fixed mode (mode = 0):
  - grant = channel select if in_valid[select] = 1.
  - If select >= NUM_CH, there is no grant ever.
  - rr_ptr is not updated.
- Round-robin mode (mode = 1):
  - Search channels starting at (rr_ptr+1) mod NUM_CH, wrapping through NUM_CH-1 to 0.
  - The first channel with in_valid = 1 is granted.
  - On a grant, rr_ptr <= granted index.
- in_ready[g] = 1 for the granted channel g only. It is combinational from in_valid, mode, select, enable, out_valid, out_ready and rr_ptr.
- A transfer from channel i occurs when in_valid[i] & in_ready[i].
- On a transfer, at the next edge: out_data <= word i, out_channel <= i, out_valid <= 1.
- If out_ready = 1 while out_valid = 1 and there is no new grant, out_valid <= 0 at the next edge. out_data and out_channel hold their last values.
- Simultaneous drain and grant: the new word replaces the drained word in the same cycle with no bubble. Full throughput is 1 word/cycle.
- out_valid = 1 and out_ready = 0: out_data and out_channel are stable; no grants (back-pressure).
- enable = 0: no new grants. A word already held still drains normally.
- Mode or select changes take effect on the next grant decision. They never alter a word already held.
- Latency: 1 cycle from input handshake to out_valid.
- No data reordering within a channel. No combinational path from in_data to out_data.

Test Plan:
- Reset then fixed mode: mode = 0, select = 5, in_valid = 8'b0010_0000, ch5 = 35'h1_2345_6789, out_ready = 1 -> in_ready = 8'b0010_0000; next cycle out_valid = 1, out_data = 35'h1_2345_6789, out_channel = 5.
- Round-robin fairness: mode = 1, all in_valid = 1, out_ready = 1 for 10 cycles after reset -> out_channel sequence 0,1,2,3,4,5,6,7,0,1 with no gaps.
- Back-pressure: hold word from ch2, out_ready = 0 for 4 cycles -> out_data and out_channel stable, in_ready = 0; out_ready = 1 with ch3 valid -> ch3 word appears the next cycle, no bubble.
- Sparse round-robin with wrap: rr_ptr = 6 (ch6 last granted), in_valid = 8'b0000_0101 -> ch0 granted, then ch2.
- Enable and out-of-range: enable = 0 with all valid -> in_ready = 0 and held word still drains; NUM_CH = 6, select = 7, mode = 0 -> no grant for 5 cycles.
- Reset mid-operation: out_valid = 1 holding ch4, reset = 1 for one cycle -> out_valid = 0 and out_data = 0 next cycle; first round-robin grant afterward goes to ch0.
